instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the 5-stage MIPS pipeline: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and drives the IF/ID register that feeds decode (`instruction`, `pc_incrementado`). It accepts the jump and branch redirects produced downstream, and the stall and flush requests from the hazard logic. It tolerates variable-latency memory and holds a fetched word in a one-entry skid buffer while decode is stalled.

## Interface
- B, 32, word width of PC, addresses and instructions
- PC_RESET, 32'h0000_0000, PC value after reset
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- stall  in  1  hazard unit: IF/ID must hold its contents
- flush  in  1  hazard unit: invalidate IF/ID this cycle
- jump  in  1  one-cycle redirect pulse; target on pc_jump
- pc_jump  in  B  jump / jr target address
- branch_taken  in  1  one-cycle redirect pulse; target on pc_branch
- pc_branch  in  B  branch target address
- imem_req  out  1  read request to instruction memory
- imem_addr  out  B  read address; equals pc
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  B  instruction word, valid only with imem_ready
- instruction  out  B  IF/ID instruction to decode (0 = NOP when invalid)
- pc_incrementado  out  B  IF/ID fetched address + 4
- if_valid  out  1  IF/ID holds a real instruction

## Operation
- States: REQ (request outstanding) and HOLD (word fetched, waiting for decode). Reset state is REQ.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - pc and imem_addr stay stable until imem_ready. A request is never withdrawn except by reset.
- Accept rule: a fetched word may enter IF/ID when `!stall || !if_valid`.
- REQ with imem_ready, no redirect active or pending:
  - If accepted: instruction<=imem_rdata, pc_incrementado<=pc+4, if_valid<=1, pc<=pc+4. Stay in REQ.
  - Otherwise: buffer<=imem_rdata, buf_pc4<=pc+4, pc<=pc+4, go to HOLD.
- HOLD:
  - imem_req=0.
  - When the accept rule holds, move buffer into IF/ID (if_valid<=1) and go to REQ.
- Redirect (jump or branch_taken high):
  - Target is pc_jump if jump=1, otherwise pc_branch. jump wins when both are high.
  - IF/ID is invalidated the same edge: if_valid<=0, instruction<=0. pc_incrementado is don't-care.
  - In REQ with imem_ready in the same cycle: discard imem_rdata, pc<=target, stay in REQ.
  - In REQ without imem_ready: latch target, set redirect_pending. The outstanding read completes at the old address. On its imem_ready the data is discarded, pc<=target and pending clears.
  - A later redirect while pending overwrites the latched target.
  - In HOLD: drop the buffer, pc<=target, go to REQ.
- flush:
  - Sets if_valid<=0 and instruction<=0, overriding stall.
  - Does not change pc, the request or the buffer. A word accepted in the same cycle is still written (fill wins over flush).
  - flush together with a redirect behaves as a redirect.
- stall with if_valid=1: instruction, pc_incrementado and if_valid hold.
- Arithmetic: pc+4 is modulo 2^B, so 32'hFFFF_FFFC+4 = 0. There is no alignment check; the low two bits pass through.

## Timing
- Reset values: pc=PC_RESET, instruction=0, pc_incrementado=0, if_valid=0, redirect_pending=0, buffer=0, state REQ. imem_req=0 while reset is low.
- First request: imem_req=1, imem_addr=PC_RESET in the first cycle after reset deasserts.
- Latency: imem_ready at edge N puts the word on instruction after edge N.
- Throughput: with zero-wait memory (imem_ready tied 1), one instruction per cycle, with consecutive addresses on consecutive cycles.
- Redirect bubble: the target address appears on imem_addr the cycle after the redirect edge, or the cycle after the discarded imem_ready if a read was pending.
- Reset mid-transaction abandons the request. Memory must accept a new request afterwards.
- imem_req, imem_addr and the outputs are registered or decoded from state only, with no combinational path from imem_ready.

## Test plan
- Reset, PC_RESET=0, imem_ready=1, memory word[a]=a: imem_addr runs 0,4,8. instruction after 3 edges = 8, pc_incrementado = 12, if_valid=1.
- Wait states: imem_ready low for 3 cycles at addr 0x10. imem_addr stays 0x10 throughout, if_valid goes 0 (or holds the prior word if stalled), then the word lands one edge after imem_ready.
- Stall: stall=1 with if_valid=1 when word 0x20 returns. FSM enters HOLD, imem_req=0, IF/ID is unchanged. Deassert stall: instruction=word(0x20), pc_incrementado=0x24, then the request for 0x24.
- Redirect while pending: jump=1, pc_jump=0x400 while the read of 0x30 waits. When ready arrives, word(0x30) never appears, if_valid=0, and the next imem_addr=0x400.
- Simultaneous jump=1 (0x100) and branch_taken=1 (0x200): next imem_addr=0x100. Separately, flush=1 with stall=1 sets if_valid=0 and instruction=0.
- Wrap: PC_RESET=32'hFFFF_FFFC gives pc_incrementado=0 and next imem_addr=0. Asserting reset mid-wait returns all outputs to their reset values at once.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch : MIPS IF stage, PC + imem req/ready + IF/ID skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module instruction_fetch #(
   parameter int           B        = 32,
   parameter logic [B-1:0] PC_RESET = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         jump,
   input  logic [B-1:0] pc_jump,
   input  logic         branch_taken,
   input  logic [B-1:0] pc_branch,
   output logic         imem_req,
   output logic [B-1:0] imem_addr,
   input  logic         imem_ready,
   input  logic [B-1:0] imem_rdata,
   output logic [B-1:0] instruction,
   output logic [B-1:0] pc_incrementado,
   output logic         if_valid
);

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [B-1:0] pc_q, pc_d;
   logic [B-1:0] instr_q, instr_d;
   logic [B-1:0] pc4_q, pc4_d;
   logic         valid_q, valid_d;
   logic         pend_q, pend_d;
   logic [B-1:0] tgt_q, tgt_d;
   logic [B-1:0] buf_q, buf_d;
   logic [B-1:0] bufpc4_q, bufpc4_d;

   logic         w_redirect;
   logic [B-1:0] w_target;
   logic         w_accept;
   logic [B-1:0] w_pc_plus4;
   logic         w_fill;
   logic [B-1:0] w_fill_word;
   logic [B-1:0] w_fill_pc4;

   assign w_redirect = jump | branch_taken;
   assign w_target   = jump ? pc_jump : pc_branch;
   assign w_accept   = !stall || !valid_q;
   assign w_pc_plus4 = pc_q + B'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      pend_d      = pend_q;
      tgt_d       = tgt_q;
      buf_d       = buf_q;
      bufpc4_d    = bufpc4_q;
      w_fill      = 1'b0;
      w_fill_word = '0;
      w_fill_pc4  = '0;

      case (state_q)
         S_REQ: begin
            if (imem_ready) begin
               // A redirect (now or pending) discards the returning word.
               if (w_redirect) begin
                  pc_d   = w_target;
                  pend_d = 1'b0;
               end else if (pend_q) begin
                  pc_d   = tgt_q;
                  pend_d = 1'b0;
               end else begin
                  pc_d = w_pc_plus4;
                  if (w_accept) begin
                     w_fill      = 1'b1;
                     w_fill_word = imem_rdata;
                     w_fill_pc4  = w_pc_plus4;
                  end else begin
                     buf_d    = imem_rdata;
                     bufpc4_d = w_pc_plus4;
                     state_d  = S_HOLD;
                  end
               end
            end else if (w_redirect) begin
               pend_d = 1'b1;
               tgt_d  = w_target;
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               pc_d    = w_target;
               state_d = S_REQ;
            end else if (w_accept) begin
               w_fill      = 1'b1;
               w_fill_word = buf_q;
               w_fill_pc4  = bufpc4_q;
               state_d     = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A fill beats flush; without a fill, an unstalled decode drains IF/ID.
      if (w_fill) begin
         instr_d = w_fill_word;
         pc4_d   = w_fill_pc4;
         valid_d = 1'b1;
      end else if (w_redirect || flush || !stall) begin
         instr_d = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_REQ;
         pc_q     <= PC_RESET;
         instr_q  <= '0;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
         pend_q   <= 1'b0;
         tgt_q    <= '0;
         buf_q    <= '0;
         bufpc4_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_q    <= pc4_d;
         valid_q  <= valid_d;
         pend_q   <= pend_d;
         tgt_q    <= tgt_d;
         buf_q    <= buf_d;
         bufpc4_q <= bufpc4_d;
      end
   end

   assign imem_req        = reset && (state_q == S_REQ);
   assign imem_addr       = pc_q;
   assign instruction     = instr_q;
   assign pc_incrementado = pc4_q;
   assign if_valid        = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Bench for instruction_fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [31:0] pc_jump = '0, pc_branch = '0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata;
   logic        imem_req, imem_req2, if_valid, if_valid2;
   logic [31:0] imem_addr, imem_addr2, instruction, instruction2, pc4, pc4_2;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] key = '0;

   always #5 clk = ~clk;

   instruction_fetch #(.B(32), .PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .jump(jump),
      .pc_jump(pc_jump), .branch_taken(branch_taken), .pc_branch(pc_branch),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instruction(instruction),
      .pc_incrementado(pc4), .if_valid(if_valid));

   instruction_fetch #(.B(32), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .jump(jump),
      .pc_jump(pc_jump), .branch_taken(branch_taken), .pc_branch(pc_branch),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instruction(instruction2),
      .pc_incrementado(pc4_2), .if_valid(if_valid2));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ key;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { logic [31:0] word; logic [31:0] pc4; } entry_t;
   entry_t      m_buf[$];
   logic [31:0] m_pc, m_instr, m_pc4, m_tgt;
   logic        m_valid, m_pend;

   task automatic model_reset();
      m_buf.delete();
      m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_tgt = '0;
      m_valid = 1'b0; m_pend = 1'b0;
   endtask

   task automatic model_step();
      logic        redir;
      logic [31:0] tgt;
      logic        can_take;
      logic        got;
      entry_t      e;
      redir    = jump || branch_taken;
      tgt      = jump ? pc_jump : pc_branch;
      can_take = !stall || !m_valid;
      got      = 1'b0;
      if (m_buf.size() != 0) begin
         if (redir) begin
            m_buf.delete();
            m_pc = tgt;
         end else if (can_take) begin
            e = m_buf.pop_front();
            got = 1'b1;
         end
      end else if (imem_ready) begin
         if (redir) begin
            m_pc = tgt; m_pend = 1'b0;
         end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
         end else begin
            e.word = mem_word(m_pc);
            e.pc4  = m_pc + 32'd4;
            m_pc   = m_pc + 32'd4;
            if (can_take) got = 1'b1;
            else m_buf.push_back(e);
         end
      end else if (redir) begin
         m_pend = 1'b1; m_tgt = tgt;
      end
      if (got) begin
         m_valid = 1'b1; m_instr = e.word; m_pc4 = e.pc4;
      end else if (redir || flush || !stall) begin
         m_valid = 1'b0; m_instr = '0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model, 1 time unit after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("m_req", {31'd0, imem_req}, {31'd0, reset && (m_buf.size() == 0)});
         if (imem_req) chk("m_addr", imem_addr, m_pc);
         chk("m_valid", {31'd0, if_valid}, {31'd0, m_valid});
         chk("m_instr", instruction, m_instr);
         if (m_valid) chk("m_pc4", pc4, m_pc4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic st, input logic fl, input logic rdy);
      stall = st; flush = fl; imem_ready = rdy;
      jump = 1'b0; branch_taken = 1'b0;
   endtask

   initial begin
      // Reset
      drive(0, 0, 1);
      repeat (3) tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_pc4", pc4, 32'd0);
      reset = 1'b1;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);

      // Zero-wait streaming
      tick();
      chk("stream_addr1", imem_addr, 32'd4);
      chk("wrap_pc4", pc4_2, 32'd0);
      chk("wrap_next_addr", imem_addr2, 32'd0);
      tick();
      chk("stream_addr2", imem_addr, 32'd8);
      tick();
      chk("stream_instr", instruction, 32'd8);
      chk("stream_pc4", pc4, 32'd12);
      chk("stream_valid", {31'd0, if_valid}, 32'd1);

      // Wait states at 0x10
      tick();
      chk("ws_addr0", imem_addr, 32'h10);
      drive(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ws_addr", imem_addr, 32'h10);
         chk("ws_valid", {31'd0, if_valid}, 32'd0);
      end
      drive(0, 0, 1);
      tick();
      chk("ws_instr", instruction, 32'h10);
      chk("ws_next", imem_addr, 32'h14);
      repeat (3) tick();
      chk("pre_stall_addr", imem_addr, 32'h20);

      // Stall while 0x20 returns
      drive(1, 0, 1);
      tick();
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", instruction, 32'h1C);
      chk("hold_pc4", pc4, 32'h20);
      tick();
      chk("hold_instr2", instruction, 32'h1C);
      drive(0, 0, 0);
      tick();
      chk("unstall_instr", instruction, 32'h20);
      chk("unstall_pc4", pc4, 32'h24);
      chk("unstall_req", {31'd0, imem_req}, 32'd1);
      chk("unstall_addr", imem_addr, 32'h24);

      // Jump while read of 0x30 is pending
      drive(0, 0, 1);
      repeat (3) tick();
      chk("pend_addr", imem_addr, 32'h30);
      drive(0, 0, 0);
      jump = 1'b1; pc_jump = 32'h400;
      tick();
      chk("pend_valid", {31'd0, if_valid}, 32'd0);
      chk("pend_addr_hold", imem_addr, 32'h30);
      drive(0, 0, 0);
      tick();
      drive(0, 0, 1);
      tick();
      chk("pend_target", imem_addr, 32'h400);
      chk("pend_discard", instruction, 32'd0);
      tick();
      chk("pend_land", instruction, 32'h400);

      // jump beats branch
      jump = 1'b1; pc_jump = 32'h100; branch_taken = 1'b1; pc_branch = 32'h200;
      tick();
      chk("prio_addr", imem_addr, 32'h100);
      drive(0, 0, 1);
      tick();
      chk("prio_instr", instruction, 32'h100);

      // flush with stall
      drive(1, 1, 0);
      tick();
      chk("flush_valid", {31'd0, if_valid}, 32'd0);
      chk("flush_instr", instruction, 32'd0);

      // Reset mid-wait clears outputs at once
      drive(0, 0, 0);
      tick();
      reset = 1'b0;
      #1;
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_addr", imem_addr, 32'd0);
      chk("async_valid", {31'd0, if_valid}, 32'd0);
      chk("async_instr", instruction, 32'd0);
      chk("async_pc4", pc4, 32'd0);
      tick();
      reset = 1'b1;
      #1;
      chk("post_rst_addr", imem_addr, 32'd0);

      // Randomized traffic
      key = $urandom;
      for (int i = 0; i < 4000; i++) begin
         stall        = ($urandom_range(0, 99) < 30);
         flush        = ($urandom_range(0, 99) < 8);
         imem_ready   = ($urandom_range(0, 99) < 65);
         jump         = ($urandom_range(0, 99) < 5);
         branch_taken = ($urandom_range(0, 99) < 6);
         pc_jump      = $urandom;
         pc_branch    = $urandom;
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         tick();
      end
      drive(0, 0, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
